// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's three channels: the instruction-memory
// request/response pair, the branch redirect and the decode-side handshake.
// The fetch stage takes the master modport. The memory, branch unit and
// decode stage (or a testbench standing in for them) take the slave modport.
interface if_fetch_stage_if;
    // Instruction-memory request channel
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;

    // Instruction-memory response channel (no back-pressure)
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    // Branch/jump redirect from later pipeline stages
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // Decode-side handshake
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruc;
    logic [63:0] id_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        output id_instruc,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        input  id_instruc,
        input  id_pc,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the RV64 pipeline.
// The stage owns the PC and keeps at most one 32-bit fetch outstanding.
// Returned words are buffered with their PC in a small FIFO for decode.
// A redirect flushes the FIFO and marks any in-flight fetch as stale, so its
// response is dropped when it arrives.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    if_fetch_stage_if.master bus
);

    localparam int unsigned       PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    // IDLE: nothing outstanding. WAIT: live fetch outstanding.
    // DROP: the outstanding fetch was overtaken by a redirect.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;

    logic [63:0]      r_pc;
    logic [63:0]      r_req_pc;
    logic [63:0]      w_pc_nxt;
    logic [63:0]      w_redirect_pc;

    logic [63:0]      r_fifo_pc  [FIFO_DEPTH];
    logic [31:0]      r_fifo_ins [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    // Redirect targets are word aligned. The two low bits are simply cleared.
    assign w_redirect_pc = bus.redirect_pc & ~64'h3;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // The issue gate uses occupancy at the start of the cycle. Because only one
    // fetch is ever outstanding, a free slot at issue is still free when the
    // response lands, so the response side needs no back-pressure.
    // reset_n gates the request so that the bus stays quiet while reset is held.
    assign w_req_valid = reset_n && (r_state == S_IDLE) && !w_full && !bus.redirect_valid;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;

    // A redirect voids any push or pop that coincides with it.
    assign w_push = (r_state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    assign w_pop  = !w_empty && bus.id_ready && !bus.redirect_valid;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    // Next-state logic: track the single outstanding fetch and its staleness.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response always closes the fetch. It is pushed only when
                // no redirect occurs in the same cycle, and w_push handles that.
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.redirect_valid) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next-PC selection: a redirect has priority over sequential advance.
    always_comb begin
        w_pc_nxt = r_pc;
        if (bus.redirect_valid) begin
            w_pc_nxt = w_redirect_pc;
        end else if (w_req_fire) begin
            w_pc_nxt = r_pc + 64'd4;
        end
    end

    // State, PC and in-flight request PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_req_fire) begin
                r_req_pc <= r_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch buffer
    // ------------------------------------------------------------------
    // Pointer and occupancy bookkeeping. A redirect empties the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: the PC and the instruction word are written together on a push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this storage is reset only because it is a few flops and decode must see zeros during reset. A deep RAM would be left unreset.
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_pc[i]  <= '0;
                r_fifo_ins[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= r_req_pc;
            r_fifo_ins[r_wr_ptr] <= bus.imem_rsp_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;

    // During a redirect cycle the old head is still shown. Decode ignores it
    // because decode is the stage that raised the redirect.
    assign bus.id_valid   = !w_empty;
    assign bus.id_instruc = r_fifo_ins[r_rd_ptr];
    assign bus.id_pc      = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage.
// The reference model holds the fetched-but-unconsumed work as a queue of
// {pc, instruction}. It also tracks whether a fetch is outstanding and whether
// that fetch went stale. A one-slot memory model answers each accepted fetch
// after a random delay.
module tb_if_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    entry_t      m_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_req_pc;
    bit          m_out;
    bit          m_stale;

    // Memory model state
    bit          mem_pend;
    int          mem_delay;
    logic [63:0] mem_addr;

    // Stimulus knobs (percentages) and one-shot forcing controls
    int          p_ready;
    int          p_idr;
    int          p_redir;
    int          max_delay;
    bit          f_redir;
    bit          f_hold;
    logic [63:0] f_pc;

    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] ins_of(logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    function automatic bit roll(int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic logic [63:0] pick_pc();
        logic [63:0] v;
        case ($urandom_range(3))
            0:       v = 64'h2002;
            1:       v = {$urandom, $urandom};
            2:       v = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(7));
            default: v = RST_PC + 64'($urandom_range(255));
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = RST_PC;
        m_req_pc = '0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
        check("rst_id_valid",   64'(bus.id_valid),       64'd0);
        check("rst_req_addr",   bus.imem_req_addr,       RST_PC);
        check("rst_id_instruc", 64'(bus.id_instruc),     64'd0);
        check("rst_id_pc",      bus.id_pc,               64'd0);
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+2, then advance the models.
    task automatic cycle();
        bit          rsp;
        bit          redir;
        bit          exp_rv;
        bit          fire;
        logic [63:0] rpc;
        logic [63:0] fire_addr;
        logic [31:0] rsp_data;

        rsp      = mem_pend && (mem_delay == 0) && !f_hold;
        redir    = f_redir || roll(p_redir);
        rpc      = f_redir ? f_pc : pick_pc();
        rsp_data = rsp ? ins_of(mem_addr) : $urandom;

        bus.imem_req_ready = roll(p_ready);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp_data;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? rpc : {$urandom, $urandom};
        bus.id_ready       = roll(p_idr);
        #1;

        exp_rv = !m_out && (m_q.size() < DEPTH) && !redir;
        check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
        check("req_addr",  bus.imem_req_addr,       m_pc);
        check("id_valid",  64'(bus.id_valid),       64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("id_pc",      bus.id_pc,           m_q[0].pc);
            check("id_instruc", 64'(bus.id_instruc), 64'(m_q[0].ins));
        end

        fire      = exp_rv && bus.imem_req_ready;
        fire_addr = m_pc;

        // Reference model update at the coming clock edge
        if (redir) begin
            m_q.delete();
            if (m_out) begin
                if (rsp) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
            m_pc = rpc & ~64'h3;
        end else begin
            if (m_q.size() != 0 && bus.id_ready) begin
                void'(m_q.pop_front());
            end
            if (m_out && rsp) begin
                if (!m_stale) begin
                    m_q.push_back('{pc: m_req_pc, ins: rsp_data});
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (fire) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 64'd4;
                m_out    = 1'b1;
            end
        end

        // Memory model update
        if (rsp) begin
            mem_pend = 1'b0;
        end else if (mem_pend && mem_delay > 0) begin
            mem_delay--;
        end
        if (fire) begin
            mem_pend  = 1'b1;
            mem_delay = int'($urandom_range(max_delay));
            mem_addr  = fire_addr;
        end

        f_redir = 1'b0;
        f_hold  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;

        n_cmp     = 0;
        n_err     = 0;
        mem_pend  = 1'b0;
        mem_delay = 0;
        mem_addr  = '0;
        f_redir   = 1'b0;
        f_hold    = 1'b0;
        f_pc      = '0;
        p_ready   = 100;
        p_idr     = 100;
        p_redir   = 0;
        max_delay = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;

        // Streaming: always ready, 1-cycle response, decode always ready
        repeat (20) cycle();

        // Back-pressure: the FIFO fills, then drains
        p_idr = 0;
        repeat (10) cycle();
        p_idr = 100;
        repeat (10) cycle();

        // Redirect to 0x2002 while a live fetch is outstanding, with no response that cycle
        max_delay = 3;
        guard = 0;
        while (!(m_out && !m_stale) && guard < 50) begin
            cycle();
            guard++;
        end
        check("reach_wait_a", 64'(guard < 50), 64'd1);
        f_redir = 1'b1;
        f_pc    = 64'h2002;
        f_hold  = 1'b1;
        cycle();
        repeat (12) cycle();

        // Redirect in the same cycle as the response
        max_delay = 0;
        guard = 0;
        while (!(m_out && !m_stale && mem_pend && mem_delay == 0) && guard < 50) begin
            cycle();
            guard++;
        end
        check("reach_wait_b", 64'(guard < 50), 64'd1);
        f_redir = 1'b1;
        f_pc    = 64'h3000;
        cycle();
        repeat (8) cycle();

        // Memory not ready: the address must stay put
        p_ready = 0;
        repeat (6) cycle();
        p_ready = 100;
        repeat (6) cycle();

        // Reset pulse while a fetch is outstanding. The late response must be ignored.
        guard = 0;
        while (!m_out && guard < 50) begin
            cycle();
            guard++;
        end
        check("reach_wait_c", 64'(guard < 50), 64'd1);
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        reset_n   = 1'b0;
        mem_delay = 1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        p_ready = 0;
        repeat (4) cycle();
        p_ready = 100;
        repeat (10) cycle();

        // Mixed random traffic
        p_ready   = 70;
        p_idr     = 60;
        p_redir   = 8;
        max_delay = 3;
        repeat (1500) cycle();
        p_idr   = 20;
        p_redir = 3;
        repeat (500) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV64 pipeline. Owns the PC, issues 32-bit fetch requests to instruction memory, and buffers returned words in a small FIFO.
- Presents {pc, instruction} to the decode stage, where the immediate generator and register-file read consume `id_instruc`.
- Supports decode back-pressure and a branch/jump redirect that flushes all fetched-but-unconsumed work.

Parameters:
- RESET_PC, 64'h0 — PC loaded on reset.
- FIFO_DEPTH, 2 — fetch-buffer entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  64  fetch address (word aligned).
- imem_rsp_valid  input  1  fetch data valid; exactly one per accepted request, no earlier than the cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  64  new fetch PC; bits [1:0] ignored (treated as 0).
- id_valid  output  1  decode output valid (FIFO non-empty).
- id_ready  input  1  decode accepts this cycle.
- id_instruc  output  32  instruction at FIFO head.
- id_pc  output  64  PC of that instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, FIFO empty, state=IDLE, req_pc=0.
  - Outputs during reset: imem_req_valid=0, id_valid=0, imem_req_addr=RESET_PC, id_instruc=0, id_pc=0.
- At most one request outstanding. States:
  - IDLE: no request outstanding.
    - imem_req_valid = (count < FIFO_DEPTH) & !redirect_valid.
    - On valid&ready: req_pc<=pc, pc<=pc+4 (64-bit wrap), go WAIT.
    - imem_rsp_valid in IDLE is ignored.
  - WAIT: request outstanding; imem_req_valid=0.
    - On imem_rsp_valid: push {req_pc, imem_rsp_data} into FIFO, go IDLE.
    - The next request may issue in the following cycle.
  - DROP: request outstanding but stale; imem_req_valid=0.
    - On imem_rsp_valid: discard the response, go IDLE.
- imem_req_addr = pc at all times. Address is stable while imem_req_valid=1 and not yet accepted.
- Issue gate counts FIFO occupancy at the start of the cycle; the single outstanding slot guarantees no overflow, so there is no rsp back-pressure.
- Decode side:
  - id_valid = FIFO non-empty; id_instruc/id_pc = head entry.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Latency:
  - First request in the first cycle after reset release.
  - Response in cycle t → id_valid in cycle t+1 (registered FIFO, no bypass).
- Redirect (highest priority):
  - In that cycle: imem_req_valid=0, pc<=redirect_pc & ~3, FIFO flushed; any pop or push that cycle is void.
  - id_valid is still shown combinationally from the old head, but decode must ignore it when it raises the redirect.
  - State after redirect:
    - WAIT with no rsp that cycle → DROP.
    - WAIT with rsp that same cycle → response discarded, IDLE.
    - DROP stays DROP unless rsp that cycle → IDLE.
    - IDLE stays IDLE.
  - Back-to-back redirects: the last one wins.
- FIFO full:
  - No request issues until a pop frees an entry.
  - A pop in cycle t allows a request to issue in cycle t+1.
- Reset asserted mid-operation: all state cleared immediately. A late response after release is ignored (state is IDLE).

Test Plan:
- Reset release with RESET_PC=0x1000, imem always ready, 1-cycle rsp, id_ready=1 → requests at 0x1000, 0x1004, 0x1008…; id_pc follows the same sequence with the matching id_instruc; one instruction every 2 cycles.
- id_ready=0 from start → FIFO fills with 2 entries (0x1000, 0x1004); imem_req_valid stays 0. Raise id_ready → pops 0x1000, then 0x1004; next request (0x1008) issues the cycle after the first pop.
- Redirect to 0x2002 while in WAIT for 0x1008 → rsp for 0x1008 dropped; FIFO empty; next request address 0x2000; first id_pc after the redirect is 0x2000.
- Redirect in the same cycle as imem_rsp_valid → response discarded; IDLE next cycle; request to the redirect PC issues that next cycle.
- imem_req_ready held low 5 cycles with valid=1 → imem_req_addr constant at 0x1000; pc advances only on acceptance.
- reset_n pulsed low while in WAIT, rsp arrives 2 cycles after release → response ignored; id_valid remains 0; fetch restarts at RESET_PC.
